wum_scan_ctrl: RTL and testbench

WUM_SCAN_CTRL -- requirements
Module: wum_scan_ctrl

---
 rtl/wum_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_wum_scan_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wum_scan_ctrl.sv
// rtl/wum_scan_ctrl.sv - Wu-Manber style block scan controller.
// Steps a window position through a data block, either skipping by the SHIFT table or running a key compare.
module wum_scan_ctrl #(
  parameter int NOS_STGS      = 4,
  parameter int NOS_KEY       = 2,
  parameter int SFT_DEL_WDH   = 4,
  parameter int SHIFT_WDH     = 4,
  parameter int POS_WDH       = 8,
  parameter int BLK_LEN       = 16,
  parameter int STOP_ON_MATCH = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 datInReady,
  input  logic [SHIFT_WDH-1:0] shift_amt,
  input  logic                 match_hit,
  output logic                 input_ready,
  output logic                 a_ld,
  output logic                 shift_amt_clr,
  output logic                 shift_amt_ld,
  output logic                 compare_enable,
  output logic                 compare_mux,
  output logic                 match_valid,
  output logic [POS_WDH-1:0]   match_pos,
  output logic                 block_done,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DEMUX, S_SHIFT, S_SDLD, S_EVAL, S_COMPARE, S_DONE
  } state_t;

  localparam int DW = SFT_DEL_WDH + 1;
  localparam int PW = POS_WDH + 1;
  localparam logic [DW-1:0] D_EN_LAST   = DW'(NOS_STGS);
  localparam logic [DW-1:0] D_MUX_FIRST = DW'(NOS_STGS + 1);
  localparam logic [DW-1:0] D_MUX_LAST  = DW'(NOS_STGS + NOS_KEY);
  localparam logic [DW-1:0] D_LAST      = DW'(NOS_STGS + NOS_KEY + 1);
  localparam logic [PW-1:0] BLK_END     = PW'(BLK_LEN);

  state_t             state_q, state_d;
  logic [DW-1:0]      d_q, d_d;
  logic [POS_WDH-1:0] pos_q, pos_d;
  logic               hit_seen_q, hit_seen_d;
  logic               match_valid_q, match_valid_d;
  logic [POS_WDH-1:0] match_pos_q, match_pos_d;

  logic               in_cmp;
  logic               cmp_mux_w;
  logic [PW-1:0]      npos_shift;
  logic [PW-1:0]      npos_inc;

  // Next positions carry one extra bit so a jump past the block end is never wrapped.
  assign npos_shift = {1'b0, pos_q} + PW'(shift_amt);
  assign npos_inc   = {1'b0, pos_q} + PW'(1);

  assign in_cmp    = (state_q == S_COMPARE);
  assign cmp_mux_w = in_cmp && (d_q >= D_MUX_FIRST) && (d_q <= D_MUX_LAST);

  assign input_ready    = (state_q == S_DEMUX);
  assign a_ld           = (state_q == S_SDLD);
  assign shift_amt_clr  = (state_q == S_IDLE) || (state_q == S_SHIFT);
  assign shift_amt_ld   = in_cmp && (d_q == D_LAST);
  assign compare_enable = in_cmp && (d_q <= D_EN_LAST);
  assign compare_mux    = cmp_mux_w;
  assign block_done     = (state_q == S_DONE);
  assign busy           = (state_q != S_IDLE);
  assign match_valid    = match_valid_q;
  assign match_pos      = match_pos_q;

  always_comb begin
    state_d       = state_q;
    d_d           = '0;
    pos_d         = pos_q;
    hit_seen_d    = hit_seen_q;
    match_valid_d = 1'b0;
    match_pos_d   = match_pos_q;
    case (state_q)
      S_IDLE: begin
        if (datInReady) state_d = S_LOAD;
      end
      S_LOAD: begin
        pos_d   = '0;
        state_d = S_DEMUX;
      end
      S_DEMUX: state_d = S_SHIFT;
      S_SHIFT: state_d = S_SDLD;
      S_SDLD:  state_d = S_EVAL;
      S_EVAL: begin
        if (shift_amt != '0) begin
          pos_d   = npos_shift[POS_WDH-1:0];
          state_d = (npos_shift >= BLK_END) ? S_DONE : S_SHIFT;
        end else begin
          hit_seen_d = 1'b0;
          state_d    = S_COMPARE;
        end
      end
      S_COMPARE: begin
        // Only the first qualified hit of a window is reported.
        if (cmp_mux_w && match_hit && !hit_seen_q) begin
          hit_seen_d    = 1'b1;
          match_valid_d = 1'b1;
          match_pos_d   = pos_q;
        end
        if (d_q == D_LAST) begin
          if ((STOP_ON_MATCH != 0) && hit_seen_q) begin
            state_d = S_DONE;
          end else begin
            pos_d   = npos_inc[POS_WDH-1:0];
            state_d = (npos_inc >= BLK_END) ? S_DONE : S_SHIFT;
          end
        end else begin
          d_d = d_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      d_q           <= '0;
      pos_q         <= '0;
      hit_seen_q    <= 1'b0;
      match_valid_q <= 1'b0;
      match_pos_q   <= '0;
    end else begin
      state_q       <= state_d;
      d_q           <= d_d;
      pos_q         <= pos_d;
      hit_seen_q    <= hit_seen_d;
      match_valid_q <= match_valid_d;
      match_pos_q   <= match_pos_d;
    end
  end

endmodule

// File: tb/tb_wum_scan_ctrl.sv
// tb/tb_wum_scan_ctrl.sv - self-checking bench for wum_scan_ctrl.
// Unit 0 runs with STOP_ON_MATCH=0, unit 1 with STOP_ON_MATCH=1; expected traces come from a window-level model.
module tb_wum_scan_ctrl;

  localparam int BLK = 16;
  localparam logic [8:0] B_BUSY = 9'h100;
  localparam logic [8:0] B_IR   = 9'h080;
  localparam logic [8:0] B_ALD  = 9'h040;
  localparam logic [8:0] B_CLR  = 9'h020;
  localparam logic [8:0] B_LD   = 9'h010;
  localparam logic [8:0] B_CE   = 9'h008;
  localparam logic [8:0] B_CM   = 9'h004;
  localparam logic [8:0] B_MV   = 9'h002;
  localparam logic [8:0] B_BD   = 9'h001;

  typedef struct {
    int         s;
    logic [7:0] mh;
  } win_t;

  win_t scr[$];

  logic       clk = 1'b0;
  logic       reset;
  logic       dat0, dat1, mh0, mh1;
  logic [3:0] sa0, sa1;

  logic u0_ir, u0_ald, u0_clr, u0_ld, u0_ce, u0_cm, u0_mv, u0_bd, u0_busy;
  logic u1_ir, u1_ald, u1_clr, u1_ld, u1_ce, u1_cm, u1_mv, u1_bd, u1_busy;
  logic [7:0] u0_mp, u1_mp;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_mp [2];

  always #5 clk = ~clk;

  wum_scan_ctrl #(.STOP_ON_MATCH(0)) u0 (
    .clk(clk), .reset(reset), .datInReady(dat0), .shift_amt(sa0), .match_hit(mh0),
    .input_ready(u0_ir), .a_ld(u0_ald), .shift_amt_clr(u0_clr), .shift_amt_ld(u0_ld),
    .compare_enable(u0_ce), .compare_mux(u0_cm), .match_valid(u0_mv), .match_pos(u0_mp),
    .block_done(u0_bd), .busy(u0_busy)
  );

  wum_scan_ctrl #(.STOP_ON_MATCH(1)) u1 (
    .clk(clk), .reset(reset), .datInReady(dat1), .shift_amt(sa1), .match_hit(mh1),
    .input_ready(u1_ir), .a_ld(u1_ald), .shift_amt_clr(u1_clr), .shift_amt_ld(u1_ld),
    .compare_enable(u1_ce), .compare_mux(u1_cm), .match_valid(u1_mv), .match_pos(u1_mp),
    .block_done(u1_bd), .busy(u1_busy)
  );

  function automatic logic [8:0] obs(input int w);
    if (w == 0) return {u0_busy, u0_ir, u0_ald, u0_clr, u0_ld, u0_ce, u0_cm, u0_mv, u0_bd};
    return {u1_busy, u1_ir, u1_ald, u1_clr, u1_ld, u1_ce, u1_cm, u1_mv, u1_bd};
  endfunction

  function automatic logic [7:0] obs_mp(input int w);
    return (w == 0) ? u0_mp : u1_mp;
  endfunction

  function automatic logic [3:0] rsa();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance past the next rising edge.
  task automatic cyc(input int w, input logic [8:0] e, input logic [3:0] s, input logic h,
                     input logic dt, input string nm);
    logic [8:0] o;
    logic [7:0] p;
    if (w == 0) begin
      dat0 = dt; sa0 = s; mh0 = h; dat1 = 1'b0;
    end else begin
      dat1 = dt; sa1 = s; mh1 = h; dat0 = 1'b0;
    end
    @(negedge clk);
    o = obs(w);
    p = obs_mp(w);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s unit%0d strobes got %b expected %b", nm, w, o, e);
    end
    checks++;
    if (p !== exp_mp[w]) begin
      errors++;
      $display("FAIL %s unit%0d match_pos got %0d expected %0d", nm, w, p, exp_mp[w]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic add_win(input int s, input logic [7:0] m);
    win_t x;
    x.s  = s;
    x.mh = m;
    scr.push_back(x);
  endtask

  task automatic fill_random();
    scr.delete();
    for (int i = 0; i < BLK; i++) begin
      int s;
      logic [7:0] m;
      s = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 15));
      m = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom) & 8'h9f;
      add_win(s, m);
    end
  endtask

  // Window-level model of one block; windows beyond the script use a shift of 8.
  task automatic run_block(input int w, input bit stop, input string nm);
    int pos, s, wi;
    bit hit, pend, done;
    logic [7:0] hb;
    logic [8:0] e;
    cyc(w, B_CLR, rsa(), rbit(), 1'b1, {nm, "_idle"});
    cyc(w, B_BUSY, rsa(), rbit(), rbit(), {nm, "_load"});
    cyc(w, B_BUSY | B_IR, rsa(), rbit(), rbit(), {nm, "_demux"});
    pos = 0; wi = 0; done = 0;
    while (!done) begin
      cyc(w, B_BUSY | B_CLR, rsa(), rbit(), rbit(), {nm, "_shift"});
      cyc(w, B_BUSY | B_ALD, rsa(), rbit(), rbit(), {nm, "_sdld"});
      if (wi < scr.size()) begin
        s = scr[wi].s; hb = scr[wi].mh;
      end else begin
        s = 8; hb = 8'h00;
      end
      wi++;
      cyc(w, B_BUSY, 4'(s), rbit(), rbit(), {nm, "_eval"});
      if (s != 0) begin
        pos  = pos + s;
        done = (pos >= BLK);
      end else begin
        hit = 0; pend = 0;
        for (int d = 0; d < 8; d++) begin
          e = B_BUSY;
          if (d <= 4) e = e | B_CE;
          if (d == 5 || d == 6) e = e | B_CM;
          if (d == 7) e = e | B_LD;
          if (pend) begin
            e = e | B_MV;
            exp_mp[w] = 8'(pos);
            pend = 0;
          end
          cyc(w, e, rsa(), hb[d], rbit(), {nm, "_compare"});
          if ((d == 5 || d == 6) && hb[d] && !hit) begin
            hit = 1; pend = 1;
          end
        end
        if (stop && hit) begin
          done = 1;
        end else begin
          pos  = pos + 1;
          done = (pos >= BLK);
        end
      end
    end
    cyc(w, B_BUSY | B_BD, rsa(), rbit(), rbit(), {nm, "_done"});
    if (w == 0) dat0 = 1'b0; else dat1 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    dat0 = 1'b0; dat1 = 1'b0; sa0 = 4'd0; sa1 = 4'd0; mh0 = 1'b0; mh1 = 1'b0;
    exp_mp[0] = 8'd0; exp_mp[1] = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (obs(w) !== B_CLR) begin
        errors++;
        $display("FAIL reset_hold unit%0d strobes got %b expected %b", w, obs(w), B_CLR);
      end
      checks++;
      if (obs_mp(w) !== 8'd0) begin
        errors++;
        $display("FAIL reset_hold unit%0d match_pos got %0d expected 0", w, obs_mp(w));
      end
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, B_CLR, rsa(), rbit(), 1'b0, "reset_after0");
    cyc(1, B_CLR, rsa(), rbit(), 1'b0, "reset_after1");
  endtask

  task automatic test_compare_basic();
    scr.delete();
    add_win(0, 8'h00);
    add_win(15, 8'h00);
    run_block(0, 0, "basic");
  endtask

  task automatic test_shift_only();
    scr.delete();
    for (int i = 0; i < 4; i++) add_win(5, 8'h00);
    run_block(0, 0, "shift5_u0");
    run_block(1, 1, "shift5_u1");
  endtask

  task automatic test_match();
    scr.delete();
    add_win(3, 8'h00);
    add_win(0, 8'h60);
    add_win(12, 8'h00);
    run_block(0, 0, "match_cont");
    run_block(1, 1, "match_stop");
  endtask

  task automatic test_hit_outside_mux();
    scr.delete();
    add_win(0, 8'h04);
    add_win(0, 8'h9f);
    add_win(14, 8'h00);
    run_block(0, 0, "nohit_u0");
    run_block(1, 1, "nohit_u1");
  endtask

  task automatic test_reset_mid();
    cyc(0, B_CLR, rsa(), rbit(), 1'b1, "rm_idle");
    cyc(0, B_BUSY, rsa(), rbit(), rbit(), "rm_load");
    cyc(0, B_BUSY | B_IR, rsa(), rbit(), rbit(), "rm_demux");
    cyc(0, B_BUSY | B_CLR, rsa(), rbit(), rbit(), "rm_shift");
    cyc(0, B_BUSY | B_ALD, rsa(), rbit(), rbit(), "rm_sdld");
    cyc(0, B_BUSY, 4'd0, rbit(), rbit(), "rm_eval");
    for (int d = 0; d < 3; d++) cyc(0, B_BUSY | B_CE, rsa(), 1'b1, rbit(), "rm_compare");
    mh0 = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    exp_mp[0] = 8'd0; exp_mp[1] = 8'd0;
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (obs(w) !== B_CLR) begin
        errors++;
        $display("FAIL rm_async unit%0d strobes got %b expected %b", w, obs(w), B_CLR);
      end
      checks++;
      if (obs_mp(w) !== 8'd0) begin
        errors++;
        $display("FAIL rm_async unit%0d match_pos got %0d expected 0", w, obs_mp(w));
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) cyc(0, B_CLR, rsa(), rbit(), 1'b0, "rm_after");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      fill_random();
      run_block(0, 0, "b2b_u0");
    end
    for (int i = 0; i < 3; i++) begin
      fill_random();
      run_block(1, 1, "b2b_u1");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      fill_random();
      run_block(0, 0, "rand_u0");
      repeat ($urandom_range(0, 3)) cyc(0, B_CLR, rsa(), rbit(), 1'b0, "rand_gap0");
      fill_random();
      run_block(1, 1, "rand_u1");
      repeat ($urandom_range(0, 3)) cyc(1, B_CLR, rsa(), rbit(), 1'b0, "rand_gap1");
    end
  endtask

  initial begin
    test_reset();
    test_compare_basic();
    test_shift_only();
    test_match();
    test_hit_outside_mux();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
